in_buff_mc: RTL and testbench
=============================

// Module: in_buff_mc
// PURPOSE
//  Multi-channel input sample FIFO: the parametrised successor to the single-lane echo input buffer.
//  Accepts one beat of CHANNELS packed ADC samples per valid/ready handshake and stores it in a DEPTH-entry circular buffer.
//  Presents beats first-word-fall-through to the downstream beamformer.
//  Reports occupancy, programmable almost-full/almost-empty watermarks and sticky overflow/underflow error flags.
// PARAMETERS
//  DATA_WIDTH  16             bits per channel sample
//  CHANNELS    4              samples per beat; beat width W = DATA_WIDTH*CHANNELS, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//  DEPTH       64             entries; must be a power of two, >= 4
//  ADDR_WIDTH  $clog2(DEPTH)  pointer width
//  AF_LEVEL    DEPTH-4        almost_full asserts when fifo_count >= AF_LEVEL
//  AE_LEVEL    4              almost_empty asserts when fifo_count <= AE_LEVEL
// PORTS
//  clk           in   1             single clock; all logic on its rising edge
//  reset         in   1             synchronous, active-high
//  in_valid      in   1             upstream beat valid
//  data_in       in   W             upstream beat
//  in_ready      out  1             buffer can accept a beat
//  out_valid     out  1             data_out holds a valid beat
//  data_out      out  W             head-of-FIFO beat
//  ready_out     in   1             downstream accepts the beat
//  clr_flags     in   1             clears overflow/underflow (sync, one cycle)
//  fifo_count    out  ADDR_WIDTH+1  entries stored, 0..DEPTH
//  almost_full   out  1             fifo_count >= AF_LEVEL
//  almost_empty  out  1             fifo_count <= AE_LEVEL
//  overflow      out  1             sticky: a beat was offered while full
//  underflow     out  1             sticky: downstream starved after streaming began
// BEHAVIOUR
//  - Reset (sync, priority over all else):
//    - wr_ptr = rd_ptr = 0, fifo_count = 0.
//    - out_valid = 0, overflow = underflow = 0, primed = 0.
//    - in_ready = 1, almost_empty = 1, almost_full = 0.
//    - Memory contents need not be cleared; data_out is don't-care while out_valid = 0.
//    - Reset mid-stream discards all stored beats; no handshake completes in the reset cycle.
//  - Status decode:
//    - in_ready = (fifo_count != DEPTH).
//    - out_valid = (fifo_count != 0).
//    - Both are decoded from registered state; there is no combinational in->out path.
//  - Push: on in_valid && in_ready, write mem[wr_ptr] and advance wr_ptr.
//  - Pop:
//    - Occurs on out_valid && ready_out; advance rd_ptr.
//    - data_out = mem[rd_ptr] combinationally (FWFT).
//  - Latency: a beat pushed at edge N is visible on data_out with out_valid = 1 after edge N (1 cycle, empty case).
//  - Pointers wrap modulo DEPTH naturally at the ADDR_WIDTH width.
//  - fifo_count update: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop or neither.
//  - Full (count = DEPTH): in_ready = 0.
//    - A same-cycle pop does NOT admit a push (no pass-through).
//  - Empty (count = 0): out_valid = 0.
//    - A same-cycle push is not bypassed to the output.
//  - Simultaneous push and pop with 0 < count < DEPTH: both complete; count is unchanged.
//  - overflow: set on in_valid && !in_ready; the offered beat is dropped and stored data is untouched.
//  - primed: set on the first push after reset.
//  - underflow: set on primed && ready_out && !out_valid.
//  - Flag clearing: clr_flags clears both flags; a set condition in the same cycle wins (flag stays 1).
//  - Watermark outputs are registered-count decodes and track fifo_count in the same cycle.
// CONFIGURATION
//  IN_BUFF_HWM_EN defined:
//    - Adds output hwm [ADDR_WIDTH:0], the peak fifo_count since reset or clr_flags.
//    - hwm updates to max(hwm, next fifo_count) each cycle.
//    - On clr_flags, hwm loads the current fifo_count.
//    - Reset value is 0.
//  IN_BUFF_HWM_EN undefined: the hwm port and its logic are absent; all other behaviour is identical.
// TESTING
//  1. CHANNELS=4, DEPTH=8: push beats 0x0001..0x0008 per lane.
//     -> popped in order; out_valid rises one cycle after the first push; fifo_count reaches 8, then 0.
//  2. Fill to 8 entries, hold in_valid one more cycle.
//     -> in_ready = 0, overflow = 1, 9th beat absent from output; clr_flags then clears overflow.
//  3. count = 4, push and pop every cycle for 20 cycles.
//     -> count stays 4, pointers wrap, data order preserved, no flags set.
//  4. Push 1 beat, pop it, keep ready_out = 1.
//     -> underflow = 1 on the next cycle; with no prior push, ready_out = 1 leaves underflow = 0.
//  5. AF_LEVEL = 6, AE_LEVEL = 2: step count 0 -> 8.
//     -> almost_empty = 1 for count <= 2; almost_full = 1 for count >= 6.
//  6. Assert reset with count = 5.
//     -> next cycle count = 0, out_valid = 0, flags 0; with IN_BUFF_HWM_EN, hwm = 0.

Source files
------------

// File: rtl/in_buff_mc.sv
// Multi-channel input sample FIFO (first-word-fall-through).
// Stores CHANNELS packed samples per beat in a DEPTH-entry circular buffer.
// Reports occupancy, almost-full/almost-empty watermarks and sticky
// overflow/underflow error flags.
// Optional feature macro: IN_BUFF_HWM_EN adds the hwm (peak occupancy) output.
//
// Handshake: a beat moves on a port only in a cycle where valid and ready
// are both high at the rising edge. in_ready and out_valid are decoded
// purely from registered occupancy, so neither depends combinationally on
// the opposite port. A full buffer refuses a push even if a pop happens in
// the same cycle; an empty buffer never bypasses an incoming beat.
module in_buff_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH*CHANNELS-1:0] data_in,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH*CHANNELS-1:0] data_out,
  input  logic                           ready_out,
  input  logic                           clr_flags,
  output logic [ADDR_WIDTH:0]            fifo_count,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic                           overflow,
  output logic                           underflow
`ifdef IN_BUFF_HWM_EN
  , output logic [ADDR_WIDTH:0]          hwm
`endif
);

  localparam int W = DATA_WIDTH * CHANNELS;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [W-1:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [ADDR_WIDTH:0]     next_count;
  logic                    primed;
  logic                    push;
  logic                    pop;
  logic                    ovf_set;
  logic                    unf_set;

  // Status decodes from registered occupancy only.
  assign in_ready     = (fifo_count != DEPTH_C);
  assign out_valid    = (fifo_count != '0);
  assign almost_full  = (fifo_count >= AF_C);
  assign almost_empty = (fifo_count <= AE_C);

  assign push    = in_valid && in_ready;
  assign pop     = out_valid && ready_out;
  assign ovf_set = in_valid && !in_ready;
  assign unf_set = primed && ready_out && !out_valid;

  // Head of FIFO is presented without a read latency.
  assign data_out = mem[rd_ptr];

  // Occupancy after this edge: simultaneous push and pop cancel out.
  always_comb begin
    next_count = fifo_count;
    if (push && !pop) begin
      next_count = fifo_count + CNT_ONE;
    end else if (pop && !push) begin
      next_count = fifo_count - CNT_ONE;
    end
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and the primed marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      primed     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        primed <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      fifo_count <= next_count;
    end
  end

  // Sticky error flags: a set condition beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
      if (unf_set) begin
        underflow <= 1'b1;
      end else if (clr_flags) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef IN_BUFF_HWM_EN
  // Peak occupancy since reset or the last flag clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      hwm <= '0;
    end else if (clr_flags) begin
      hwm <= fifo_count;
    end else if (next_count > hwm) begin
      hwm <= next_count;
    end
  end
`endif

endmodule

// File: tb/tb_in_buff_mc.sv
// Directed bench for in_buff_mc (CHANNELS=4, DEPTH=8, AF=6, AE=2).
// A reference occupancy/flag model and an expected-data queue supply every
// expected value; outputs are checked #1 after each rising edge.
module tb_in_buff_mc;

  localparam int DW    = 16;
  localparam int CH    = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int W     = DW * CH;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  data_in;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  data_out;
  logic          ready_out;
  logic          clr_flags;
  logic [AW:0]   fifo_count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;
`ifdef IN_BUFF_HWM_EN
  logic [AW:0]   hwm;
  int            m_hwm;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int           mc;
  logic         m_ovf;
  logic         m_unf;
  logic         m_primed;
  logic [W-1:0] exp_q[$];

  in_buff_mc #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH),
    .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .data_in(data_in), .in_ready(in_ready),
    .out_valid(out_valid), .data_out(data_out), .ready_out(ready_out),
    .clr_flags(clr_flags), .fifo_count(fifo_count),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
`ifdef IN_BUFF_HWM_EN
    , .hwm(hwm)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] beat(input int v);
    logic [DW-1:0] s;
    s = DW'(v);
    return {s, s, s, s};
  endfunction

  task automatic model_reset();
    mc       = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_primed = 1'b0;
    exp_q.delete();
`ifdef IN_BUFF_HWM_EN
    m_hwm = 0;
`endif
  endtask

  // Drive one cycle: check outputs against the model, then advance an edge.
  task automatic do_cycle(input logic iv, input logic [W-1:0] din,
                          input logic ro, input logic clr);
    logic push_e, pop_e, ovf_s, unf_s;
    int   nc;
    logic [W-1:0] e;
    in_valid  = iv;
    data_in   = din;
    ready_out = ro;
    clr_flags = clr;
    #1;
    check("in_ready",     W'(in_ready),     W'(mc != DEPTH));
    check("out_valid",    W'(out_valid),    W'(mc != 0));
    check("fifo_count",   W'(fifo_count),   W'(mc));
    check("almost_full",  W'(almost_full),  W'(mc >= 6));
    check("almost_empty", W'(almost_empty), W'(mc <= 2));
    check("overflow",     W'(overflow),     W'(m_ovf));
    check("underflow",    W'(underflow),    W'(m_unf));
`ifdef IN_BUFF_HWM_EN
    check("hwm",          W'(hwm),          W'(m_hwm));
`endif
    push_e = iv && (mc != DEPTH);
    pop_e  = ro && (mc != 0);
    ovf_s  = iv && (mc == DEPTH);
    unf_s  = m_primed && ro && (mc == 0);
    if (pop_e) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL scoreboard_empty observed=pop expected=no_pop");
      end else begin
        e = exp_q.pop_front();
        check("data_out", data_out, e);
      end
    end
    if (push_e) exp_q.push_back(din);
    nc = mc + (push_e ? 1 : 0) - (pop_e ? 1 : 0);
`ifdef IN_BUFF_HWM_EN
    if (clr) m_hwm = mc;
    else if (nc > m_hwm) m_hwm = nc;
`endif
    m_ovf = ovf_s ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = unf_s ? 1'b1 : (clr ? 1'b0 : m_unf);
    if (push_e) m_primed = 1'b1;
    mc = nc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    data_in   = beat(16'hdead);
    ready_out = 1'b1;
    clr_flags = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    ready_out = 1'b0;
    clr_flags = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    do_cycle(1'b0, '0, 1'b0, 1'b0);

    // 1: push 1..8 per lane, then drain in order
    for (int i = 1; i <= 8; i++) do_cycle(1'b1, beat(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)  do_cycle(1'b0, '0, 1'b1, 1'b0);

    // 2: fill, offer a ninth beat, then clear overflow and drain
    for (int i = 0; i < 8; i++) do_cycle(1'b1, beat(16'h20 + i), 1'b0, 1'b0);
    do_cycle(1'b1, beat(16'h99), 1'b0, 1'b0);
    do_cycle(1'b1, beat(16'h98), 1'b1, 1'b0);   // full + pop: no pass-through
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);

    // 3: hold count at 4 with push+pop for 20 cycles
    for (int i = 0; i < 4; i++) do_cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) do_cycle(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);

    // 4: starve downstream after streaming, then clear (set wins while ready held)
    do_cycle(1'b1, beat(16'h44), 1'b0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b1);
    do_cycle(1'b0, '0, 1'b0, 1'b1);
    do_cycle(1'b0, '0, 1'b0, 1'b0);

    // 4b: no push since reset, ready_out alone must not flag underflow
    do_reset();
    for (int i = 0; i < 3; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);

    // Empty + push: not bypassed to the output
    do_cycle(1'b1, beat(16'h55), 1'b1, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0);

    // 5: step count 0 -> 8 for watermarks, then drain to 5
    for (int i = 0; i < 8; i++) do_cycle(1'b1, beat(16'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, '0, 1'b1, 1'b0);

    // 6: reset with count = 5
    do_reset();
    do_cycle(1'b0, '0, 1'b0, 1'b0);
    do_cycle(1'b1, beat(16'h77), 1'b0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    do_cycle(1'b0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
